// File: rtl/flipflop_bank_pkg.sv
// Shared mode encodings for the flip-flop bank.
// Optional change counter is enabled by defining FLIPFLOP_BANK_CNT_EN.
package flipflop_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_D    = 2'b01,
        MODE_T    = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

endpackage

// File: rtl/flipflop_cell.sv
// One-bit next-state logic for a JK / D / T / hold flip-flop channel.
// Purely combinational; the state register lives in flipflop_bank.
import flipflop_bank_pkg::*;

module flipflop_cell (
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       q,
    output logic       q_nxt
);

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            MODE_D:  q_nxt = j;
            MODE_T:  q_nxt = q ^ j;
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/flipflop_bank.sv
// Bank of WIDTH independent JK/D/T flip-flops with parallel load and change mask.
// Define FLIPFLOP_BANK_CNT_EN to add the saturating change counter (change_cnt, cnt_clr).
import flipflop_bank_pkg::*;

module flipflop_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] en_mask,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef FLIPFLOP_BANK_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] change_cnt,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] changed
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] cell_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        flipflop_cell u_cell (
            .mode  (mode),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q_q[i]),
            .q_nxt (cell_nxt[i])
        );
    end

    // Load bypasses enable, mask and mode entirely.
    always_comb begin
        if (load) begin
            q_d = load_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q_d[i] = (enable && en_mask[i]) ? cell_nxt[i] : q_q[i];
            end
        end
        changed_d = q_q ^ q_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RESET_VAL;
            changed_q <= '0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
        end
    end

`ifdef FLIPFLOP_BANK_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((changed_d != '0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign change_cnt = cnt_q;
`endif

    assign q       = q_q;
    assign qn      = ~q_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_flipflop_bank.sv
// Directed self-checking bench for flipflop_bank (RESET_VAL = 8'hA5).
// Counter checks, including a CNT_W=2 saturation instance, compile in with FLIPFLOP_BANK_CNT_EN.
`timescale 1ns/1ps
import flipflop_bank_pkg::*;

module tb_flipflop_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] en_mask, j, k, load_val;
    logic       load;
    logic [7:0] q, qn, changed;
`ifdef FLIPFLOP_BANK_CNT_EN
    logic       cnt_clr;
    logic [7:0] change_cnt;
    logic [1:0] sat_cnt;
    logic [7:0] sat_q, sat_qn, sat_changed;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flipflop_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .en_mask  (en_mask),
        .j        (j),
        .k        (k),
        .load     (load),
        .load_val (load_val),
`ifdef FLIPFLOP_BANK_CNT_EN
        .cnt_clr    (cnt_clr),
        .change_cnt (change_cnt),
`endif
        .q        (q),
        .qn       (qn),
        .changed  (changed)
    );

`ifdef FLIPFLOP_BANK_CNT_EN
    flipflop_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .en_mask    (en_mask),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_val   (load_val),
        .cnt_clr    (cnt_clr),
        .change_cnt (sat_cnt),
        .q          (sat_q),
        .qn         (sat_qn),
        .changed    (sat_changed)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] jk_vec  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [7:0] jk_q    [5] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] jk_chg  [5] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] t_q     [5] = '{8'hC3, 8'h3C, 8'hC3, 8'h3C, 8'hC3};

    initial begin
        reset = 1'b1; enable = 1'b0; mode = MODE_HOLD; en_mask = '0;
        j = '0; k = '0; load = 1'b0; load_val = '0;
`ifdef FLIPFLOP_BANK_CNT_EN
        cnt_clr = 1'b0;
`endif
        tick(); tick();
        chk("rst_q", q, 8'hA5);
        chk("rst_qn", qn, 8'h5A);
        chk("rst_changed", changed, 8'h00);
`ifdef FLIPFLOP_BANK_CNT_EN
        chk("rst_cnt", change_cnt, 8'd0);
`endif

        reset = 1'b0; load = 1'b1; load_val = 8'h00;
        tick();
        chk("load0_q", q, 8'h00);
        chk("load0_changed", changed, 8'hA5);
        load = 1'b0;

        enable = 1'b1; mode = MODE_JK; en_mask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            j = {8{jk_vec[i][1]}};
            k = {8{jk_vec[i][0]}};
            tick();
            chk($sformatf("jk%0d_q", i), q, jk_q[i]);
            chk($sformatf("jk%0d_changed", i), changed, jk_chg[i]);
        end
        chk("jk_qn", qn, 8'h00);

        mode = MODE_HOLD; j = 8'h55; k = 8'hAA;
        tick();
        chk("hold_q", q, 8'hFF);
        chk("hold_changed", changed, 8'h00);

        load = 1'b1; load_val = 8'h00;
        tick();
        load = 1'b0; mode = MODE_D; en_mask = 8'h0F; j = 8'hFF;
        tick();
        chk("mask_q", q, 8'h0F);
        chk("mask_changed", changed, 8'h0F);
        enable = 1'b0; j = 8'h00;
        tick();
        chk("dis_q", q, 8'h0F);
        chk("dis_changed", changed, 8'h00);

        mode = MODE_HOLD; load = 1'b1; load_val = 8'h3C;
        tick();
        chk("ldpri_q", q, 8'h3C);
        chk("ldpri_changed", changed, 8'h33);
        reset = 1'b1; load_val = 8'hC3;
        tick();
        chk("rst_over_load_q", q, 8'hA5);
        chk("rst_over_load_changed", changed, 8'h00);
        reset = 1'b0; load_val = 8'h3C;
`ifdef FLIPFLOP_BANK_CNT_EN
        cnt_clr = 1'b1;
`endif
        tick();
        chk("reload_q", q, 8'h3C);
        chk("reload_changed", changed, 8'h99);
`ifdef FLIPFLOP_BANK_CNT_EN
        chk("clr_pri_cnt", change_cnt, 8'd0);
        cnt_clr = 1'b0;
`endif
        load = 1'b0;

        enable = 1'b1; mode = MODE_T; en_mask = 8'hFF; j = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t%0d_q", i), q, t_q[i]);
            chk($sformatf("t%0d_changed", i), changed, 8'hFF);
`ifdef FLIPFLOP_BANK_CNT_EN
            chk($sformatf("t%0d_cnt", i), change_cnt, 32'(i + 1));
            chk($sformatf("t%0d_sat", i), sat_cnt, (i < 3) ? 32'(i + 1) : 32'd3);
`endif
        end

        reset = 1'b1;
        tick();
        chk("midrun_rst_q", q, 8'hA5);
        chk("midrun_rst_changed", changed, 8'h00);
        reset = 1'b0;

`ifdef FLIPFLOP_BANK_CNT_EN
        tick();
        chk("cnt_pre_clr", change_cnt, 8'd1);
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr", change_cnt, 8'd0);
        chk("sat_clr", sat_cnt, 2'd0);
        cnt_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
